regfile_multiport: RTL

// - Parametrised CPU register file: NUM_REGS x DATA_WIDTH, NUM_RD_PORTS registered read ports, one write port.
// - Sits between REG stage (reads) and WB stage (writes); drop-in successor for a 2-read/1-write, 16x32 bank.
// - Adds a hardware init/flush sequencer, because the storage array is RAM-inferable and has no reset.
//

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_init_seq.sv | 57 +++++
 rtl/regfile_multiport.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: sequencer state encoding
// and the default geometry used by the CPU top.
package regfile_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_INIT = 1'b1
  } seq_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 16;

endpackage : regfile_pkg

// File: rtl/regfile_init_seq.sv
// Init/flush sequencer: walks every register address once, emitting a zero
// write per cycle, after reset and on each flush request seen while idle.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  busy,
  output logic                  seq_we,
  output logic [ADDR_WIDTH-1:0] seq_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

  seq_state_e state;

  // State, address counter and busy flag; busy mirrors SEQ_INIT as a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEQ_INIT;
      seq_addr <= ZERO_ADDR;
      busy     <= 1'b1;
    end else begin
      case (state)
        SEQ_INIT: begin
          if (seq_addr == LAST_ADDR) begin
            state    <= SEQ_IDLE;
            seq_addr <= ZERO_ADDR;
            busy     <= 1'b0;
          end else begin
            seq_addr <= seq_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        SEQ_IDLE: begin
          if (flush) begin
            state    <= SEQ_INIT;
            seq_addr <= ZERO_ADDR;
            busy     <= 1'b1;
          end
        end
        default: begin
          state    <= SEQ_INIT;
          seq_addr <= ZERO_ADDR;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  assign seq_we = busy;

endmodule : regfile_init_seq

// File: rtl/regfile_multiport.sv
// Multiport register file: NUM_RD_PORTS registered read ports, one write port,
// reset-free RAM copies zeroed by a hardware sequencer. Optional debug read
// port enabled by defining REGFILE_DEBUG_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int NUM_RD_PORTS = 2,
  localparam int ADDR_WIDTH  = $clog2(NUM_REGS),
  parameter int ZERO_REG     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic                               hold,
  input  logic                               clear,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               flush,
`ifdef REGFILE_DEBUG_EN
  input  logic [ADDR_WIDTH-1:0]              dbg_addr,
  output logic [DATA_WIDTH-1:0]              dbg_data,
`endif
  output logic                               busy
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};
  localparam logic                  HAS_ZERO  = (ZERO_REG != 0);

  logic                  seq_we;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_data;
  logic [DATA_WIDTH-1:0] rd_q [NUM_RD_PORTS];

  regfile_init_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_init_seq (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .busy     (busy),
    .seq_we   (seq_we),
    .seq_addr (seq_addr)
  );

  // Array write port: the sequencer owns it while busy, WB otherwise.
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = ZERO_ADDR;
    arr_data = ZERO_DATA;
    if (busy) begin
      arr_we   = seq_we;
      arr_addr = seq_addr;
    end else begin
      arr_we   = wr_en && !(HAS_ZERO && (wr_addr == ZERO_ADDR));
      arr_addr = wr_addr;
      arr_data = wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [ADDR_WIDTH-1:0] addr;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // One RAM copy per read port, all fed by the shared write port.
    always_ff @(posedge clk) begin
      if (arr_we) begin
        mem[arr_addr] <= arr_data;
      end
    end

    // Registered read; a same-cycle WB write to the read address bypasses the array.
    always_ff @(posedge clk) begin
      if (reset || busy) begin
        rd_q[p] <= ZERO_DATA;
      end else if (clear) begin
        rd_q[p] <= ZERO_DATA;
      end else if (hold) begin
        rd_q[p] <= rd_q[p];
      end else if (HAS_ZERO && (addr == ZERO_ADDR)) begin
        rd_q[p] <= ZERO_DATA;
      end else if (wr_en && (wr_addr == addr)) begin
        rd_q[p] <= wr_data;
      end else begin
        rd_q[p] <= mem[addr];
      end
    end
  end

  // Pack per-port registers onto the flat output bus.
  always_comb begin
    rd_data = {(NUM_RD_PORTS*DATA_WIDTH){1'b0}};
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
    end
  end

`ifdef REGFILE_DEBUG_EN
  logic [DATA_WIDTH-1:0] dbg_mem [NUM_REGS];

  // Debug copy sees raw array contents, independent of read-port controls.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      dbg_mem[arr_addr] <= arr_data;
    end
  end

  // Debug read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_data <= ZERO_DATA;
    end else begin
      dbg_data <= dbg_mem[dbg_addr];
    end
  end
`endif

endmodule : regfile_multiport
